// File: rtl/rggen_rtl_pkg.sv
// Shared register-access types: request direction, response status, and a
// sizing helper for the optional wait-state timeout counter.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  // Counter only needs to reach limit-1, so clog2(limit) bits; never fewer than one.
  function automatic int timeout_count_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/rggen_apb_if.sv
// APB4 signal bundle; the master modport drives the transfer, the slave
// modport returns completion, read data and error.
interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic                     pwrite;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/rggen_timeout_counter.sv
// Counts ACCESS cycles and flags expiry on the LIMIT-th cycle without
// completion; LIMIT == 0 yields a counter that never expires.
module rggen_timeout_counter
  import rggen_rtl_pkg::*;
#(
  parameter int LIMIT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  generate
    if (LIMIT > 0) begin : g_counter
      localparam int CW = timeout_count_width(LIMIT);

      logic [CW-1:0] count;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable) begin
          count <= count + 1'b1;
        end
      end

      // The owner leaves ACCESS on expiry, so the count never wraps.
      assign expire = enable && (count == CW'(LIMIT - 1));
    end else begin : g_tie_off
      logic armed;

      // Disabled timeout: a token flop keeps the port list uniform, output is constant 0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          armed <= 1'b0;
        end else begin
          armed <= enable & ~clear;
        end
      end

      assign expire = armed & 1'b0;
    end
  endgenerate

endmodule

// File: rtl/rggen_apb_master_bridge.sv
// Valid/ready request to APB4 requester: one outstanding SETUP/ACCESS
// transfer, response held until consumed, optional wait-state timeout.
module rggen_apb_master_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDRESS_WIDTH-1:0]  req_address,
  input  logic                      req_write,
  input  logic [DATA_WIDTH-1:0]     req_write_data,
  input  logic [DATA_WIDTH/8-1:0]   req_strobe,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_read_data,
  output logic [1:0]                rsp_status,
  rggen_apb_if.master               apb_if
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESPONSE
  } state_e;

  state_e                    state;
  logic                      req_ready_q;
  logic                      psel_q;
  logic                      penable_q;
  logic [ADDRESS_WIDTH-1:0]  paddr_q;
  rggen_direction            pwrite_q;
  logic [DATA_WIDTH-1:0]     pwdata_q;
  logic [DATA_WIDTH/8-1:0]   pstrb_q;
  logic                      rsp_valid_q;
  logic [DATA_WIDTH-1:0]     rsp_read_data_q;
  rggen_status               rsp_status_q;
  logic                      timeout_expire;

  rggen_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state == ACCESS),
    .clear  (state == SETUP),
    .expire (timeout_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_ready_q     <= 1'b0;
      psel_q          <= 1'b0;
      penable_q       <= 1'b0;
      paddr_q         <= '0;
      pwrite_q        <= RGGEN_READ;
      pwdata_q        <= '0;
      pstrb_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_read_data_q <= '0;
      rsp_status_q    <= RGGEN_OKAY;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            paddr_q     <= req_address;
            pwrite_q    <= rggen_direction'(req_write);
            pwdata_q    <= req_write_data;
            pstrb_q     <= req_write ? req_strobe : '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so a completion on the expiry cycle still wins.
          if (apb_if.pready) begin
            psel_q          <= 1'b0;
            penable_q       <= 1'b0;
            rsp_valid_q     <= 1'b1;
            rsp_read_data_q <= (pwrite_q == RGGEN_WRITE) ? '0 : apb_if.prdata;
            rsp_status_q    <= apb_if.pslverr ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
            state           <= RESPONSE;
          end else if (timeout_expire) begin
            psel_q          <= 1'b0;
            penable_q       <= 1'b0;
            rsp_valid_q     <= 1'b1;
            rsp_read_data_q <= '0;
            rsp_status_q    <= RGGEN_DECODE_ERROR;
            state           <= RESPONSE;
          end
        end
        RESPONSE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_read_data  = rsp_read_data_q;
  assign rsp_status     = rsp_status_q;

  assign apb_if.psel    = psel_q;
  assign apb_if.penable = penable_q;
  assign apb_if.paddr   = paddr_q;
  assign apb_if.pwrite  = pwrite_q;
  assign apb_if.pwdata  = pwdata_q;
  assign apb_if.pstrb   = pstrb_q;

endmodule

// File: tb/tb_rggen_apb_master_bridge.sv
// Directed bench for the APB requester bridge with an 8-cycle timeout.
module tb_rggen_apb_master_bridge;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam logic [1:0] ST_OKAY   = 2'b00;
  localparam logic [1:0] ST_SLVERR = 2'b10;
  localparam logic [1:0] ST_DECERR = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_address = '0;
  logic          req_write = 1'b0;
  logic [DW-1:0] req_write_data = '0;
  logic [3:0]    req_strobe = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_read_data;
  logic [1:0]    rsp_status;

  int errors = 0;
  int checks = 0;

  rggen_apb_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) apb ();

  rggen_apb_master_bridge #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_address    (req_address),
    .req_write      (req_write),
    .req_write_data (req_write_data),
    .req_strobe     (req_strobe),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_read_data  (rsp_read_data),
    .rsp_status     (rsp_status),
    .apb_if         (apb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=stuck required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [3:0] strb);
    req_valid      = 1'b1;
    req_write      = wr;
    req_address    = addr;
    req_write_data = wdata;
    req_strobe     = strb;
  endtask

  initial begin
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_psel", apb.psel, 0);
    chk("rst_penable", apb.penable, 0);
    chk("rst_paddr", apb.paddr, 0);
    chk("rst_pwrite", apb.pwrite, 0);
    chk("rst_pwdata", apb.pwdata, 0);
    chk("rst_pstrb", apb.pstrb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_read_data, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_req_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req_ready", req_ready, 1);

    // Read, no wait states
    apb.pready = 1'b1;
    apb.prdata = 32'hCAFE_F00D;
    issue(1'b0, 16'h0010, 32'hFFFF_FFFF, 4'hF);
    tick();
    req_valid = 1'b0;
    chk("rd_setup_psel", apb.psel, 1);
    chk("rd_setup_penable", apb.penable, 0);
    chk("rd_setup_paddr", apb.paddr, 16'h0010);
    chk("rd_setup_pwrite", apb.pwrite, 0);
    chk("rd_setup_pstrb", apb.pstrb, 0);
    chk("rd_setup_req_ready", req_ready, 0);
    tick();
    chk("rd_access_psel", apb.psel, 1);
    chk("rd_access_penable", apb.penable, 1);
    tick();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_read_data, 32'hCAFE_F00D);
    chk("rd_rsp_status", rsp_status, ST_OKAY);
    chk("rd_rsp_psel", apb.psel, 0);
    chk("rd_rsp_penable", apb.penable, 0);
    rsp_ready = 1'b1;
    tick();
    chk("rd_done_rsp_valid", rsp_valid, 0);
    chk("rd_done_req_ready", req_ready, 1);

    // Write with 3 wait states
    apb.pready = 1'b0;
    issue(1'b1, 16'h0124, 32'h1234_5678, 4'b0101);
    tick();
    req_valid = 1'b0;
    chk("wr_setup_psel", apb.psel, 1);
    chk("wr_setup_pstrb", apb.pstrb, 4'b0101);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wr_access_penable", apb.penable, 1);
      chk("wr_access_paddr", apb.paddr, 16'h0124);
      chk("wr_access_pwdata", apb.pwdata, 32'h1234_5678);
      chk("wr_access_pstrb", apb.pstrb, 4'b0101);
      chk("wr_access_pwrite", apb.pwrite, 1);
      chk("wr_access_rsp_valid", rsp_valid, 0);
    end
    apb.pready = 1'b1;
    tick();
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_data", rsp_read_data, 0);
    chk("wr_rsp_status", rsp_status, ST_OKAY);
    tick();
    chk("wr_done_req_ready", req_ready, 1);

    // Slave error on a write, then on a read
    apb.pslverr = 1'b1;
    apb.prdata  = 32'hDEAD_BEEF;
    issue(1'b1, 16'h0200, 32'hA5A5_A5A5, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("slverr_wr_rsp_valid", rsp_valid, 1);
    chk("slverr_wr_status", rsp_status, ST_SLVERR);
    chk("slverr_wr_data", rsp_read_data, 0);
    tick();
    issue(1'b0, 16'h0204, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("slverr_rd_status", rsp_status, ST_SLVERR);
    chk("slverr_rd_data", rsp_read_data, 32'hDEAD_BEEF);
    tick();
    apb.pslverr = 1'b0;

    // Timeout: pready never arrives
    apb.pready = 1'b0;
    issue(1'b0, 16'h0300, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to_access_psel", apb.psel, 1);
      chk("to_access_penable", apb.penable, 1);
    end
    tick();
    chk("to_psel_dropped", apb.psel, 0);
    chk("to_penable_dropped", apb.penable, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_status", rsp_status, ST_DECERR);
    chk("to_data", rsp_read_data, 0);
    tick();

    // Timeout boundary: pready in the 8th ACCESS cycle wins
    apb.prdata = 32'h0BAD_CAFE;
    issue(1'b0, 16'h0304, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("to8_penable", apb.penable, 1);
    apb.pready = 1'b1;
    tick();
    chk("to8_rsp_valid", rsp_valid, 1);
    chk("to8_status", rsp_status, ST_OKAY);
    chk("to8_data", rsp_read_data, 32'h0BAD_CAFE);
    tick();

    // Response backpressure with a pending new request
    rsp_ready  = 1'b0;
    apb.prdata = 32'h1122_3344;
    issue(1'b0, 16'h0010, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    issue(1'b1, 16'h0400, 32'h5555_AAAA, 4'hC);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_read_data, 32'h1122_3344);
      chk("bp_rsp_status", rsp_status, ST_OKAY);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_psel", apb.psel, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_rsp_valid", rsp_valid, 0);
    chk("bp_release_req_ready", req_ready, 1);
    chk("bp_release_psel", apb.psel, 0);
    tick();
    req_valid = 1'b0;
    chk("bp_next_psel", apb.psel, 1);
    chk("bp_next_paddr", apb.paddr, 16'h0400);
    chk("bp_next_pwrite", apb.pwrite, 1);
    chk("bp_next_pstrb", apb.pstrb, 4'hC);
    tick();
    tick();
    chk("bp_next_rsp_status", rsp_status, ST_OKAY);
    chk("bp_next_rsp_data", rsp_read_data, 0);
    tick();

    // Reset mid-ACCESS
    apb.pready = 1'b0;
    issue(1'b0, 16'h0500, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("mid_rst_pre_penable", apb.penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_psel", apb.psel, 0);
    chk("mid_rst_penable", apb.penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_after_rsp_valid", rsp_valid, 0);
    chk("mid_rst_after_req_ready", req_ready, 1);
    apb.pready = 1'b1;
    apb.prdata = 32'hCAFE_F00D;
    issue(1'b0, 16'h0010, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("fresh_psel", apb.psel, 1);
    tick();
    tick();
    chk("fresh_rsp_valid", rsp_valid, 1);
    chk("fresh_rsp_data", rsp_read_data, 32'hCAFE_F00D);
    chk("fresh_rsp_status", rsp_status, ST_OKAY);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rggen_apb_master_bridge.md
# rggen_apb_master_bridge

APB4 requester that converts a simple valid/ready register-access request into a compliant APB SETUP/ACCESS transfer and returns read data and status on a valid/ready response channel. Sits directly upstream of the APB host interface and drives its APB slave port, so a CPU-side or test-side request source can reach the register block. Optionally enforces a wait-state timeout on unresponsive slaves.

## Interface
- ADDRESS_WIDTH, 16, width of req_address / paddr
- DATA_WIDTH, 32, data width; must be a multiple of 8
- TIMEOUT_CYCLES, 0, max ACCESS cycles without pready; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid && ready
- req_address  in  ADDRESS_WIDTH  byte address
- req_write  in  1  1 = write, 0 = read (rggen_direction)
- req_write_data  in  DATA_WIDTH  write data
- req_strobe  in  DATA_WIDTH/8  byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid && ready
- rsp_read_data  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_status  out  2  rggen_status: OKAY, SLAVE_ERROR (pslverr), DECODE_ERROR (timeout)
- apb_if  rggen_apb_if.master  —  psel, penable, paddr, pwrite, pwdata, pstrb out; pready, prdata, pslverr in

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESPONSE.
- IDLE: req_ready = 1. On req_valid, capture the request into APB output registers and go to SETUP.
- SETUP: psel = 1, penable = 0. Unconditionally go to ACCESS.
- ACCESS: psel = 1, penable = 1. On pready, capture:
  - prdata if a read, 0 if a write;
  - status = SLAVE_ERROR if pslverr, else OKAY.
  - Then go to RESPONSE.
- Timeout: the counter clears on entering ACCESS. When TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES-1 without pready:
  - drop psel/penable;
  - status = DECODE_ERROR, read data = 0;
  - go to RESPONSE.
  - If pready arrives on the same cycle as the timeout, pready wins.
- RESPONSE: rsp_valid = 1, data and status held stable until rsp_ready. Then go to IDLE.
- req_ready is high only in IDLE. One outstanding transfer. No request buffering.
- paddr, pwrite, pwdata and pstrb are stable from SETUP through the end of ACCESS. pstrb is driven 0 for reads.
- Address is passed unmodified; no alignment check.

## Timing
- Reset value of every output: psel, penable, paddr, pwrite, pwdata, pstrb, rsp_valid, rsp_read_data, rsp_status all 0; req_ready 0 during reset, 1 from the first cycle after release.
- Request accepted at edge N:
  - psel high in cycle N+1;
  - penable high in cycle N+2;
  - if pready is high in N+2, rsp_valid is high in N+3.
- Minimum is 4 cycles per transfer. Each APB wait state adds 1 cycle.
- With rsp_ready held high, req_ready returns in the cycle after rsp_valid.
- Reset asserted mid-transfer: psel/penable drop immediately (asynchronous). The transfer is lost and no response is issued.
- Back-to-back requests never overlap; psel is deasserted for at least one cycle (RESPONSE) between transfers.

## Structure
- rggen_rtl_pkg already holds rggen_direction and rggen_status; use those.
- The FSM state enum is local to the module.
- Natural sub-module: rggen_timeout_counter (enable, clear, expire; parameterised limit, tied off when TIMEOUT_CYCLES == 0).

## Test plan
- Read, no wait states: req address 0x0010, pready in first ACCESS cycle, prdata 0xCAFE_F00D -> SETUP/ACCESS one cycle each, rsp_read_data 0xCAFE_F00D, status OKAY, rsp_valid 3 cycles after accept.
- Write with 3 wait states: data 0x1234_5678, strobe 0b0101 -> pwdata/pstrb/paddr stable for all 4 ACCESS cycles, rsp_read_data 0, status OKAY.
- Slave error: pslverr = 1 with pready -> status SLAVE_ERROR, read data 0x0 for a write, prdata passed through for a read.
- Timeout with TIMEOUT_CYCLES = 8, pready never high -> psel drops after 8 ACCESS cycles, status DECODE_ERROR; a second case with pready in the 8th cycle -> OKAY.
- Response backpressure: rsp_ready low for 5 cycles -> rsp_valid, data and status held; req_ready stays low; a new req_valid is not accepted until after the handshake.
- Reset mid-ACCESS: assert rst_n low during wait states -> psel/penable 0 immediately, no rsp_valid; after release, a fresh read completes normally.
